// File: rtl/lagarto_dcache_port_arbiter.sv
// lagarto_dcache_port_arbiter: shares the L1 D-cache request port between the load and store paths.
// Load-priority arbitration with a store starvation guard, two-phase index/tag sequencing, load tracking.
`default_nettype none

module lagarto_dcache_port_arbiter #(
    parameter int IDX_W      = 12,
    parameter int TAG_W      = 44,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             ld_valid_i,
    output logic             ld_ack_o,
    input  logic [IDX_W-1:0] ld_index_i,
    input  logic [TAG_W-1:0] ld_tag_i,
    input  logic [63:0]      ld_wdata_i,
    input  logic [7:0]       ld_be_i,
    input  logic [1:0]       ld_size_i,
    input  logic             ld_kill_i,
    input  logic             st_valid_i,
    output logic             st_ack_o,
    input  logic [IDX_W-1:0] st_index_i,
    input  logic [TAG_W-1:0] st_tag_i,
    input  logic [63:0]      st_wdata_i,
    input  logic [7:0]       st_be_i,
    input  logic [1:0]       st_size_i,
    input  logic             st_kill_i,
    output logic             ld_resp_valid_o,
    output logic [63:0]      ld_resp_data_o,
    output logic             st_done_o,
    output logic             mem_valid_o,
    input  logic             mem_gnt_i,
    output logic [IDX_W-1:0] mem_index_o,
    output logic [TAG_W-1:0] mem_tag_o,
    output logic [63:0]      mem_wdata_o,
    output logic             mem_we_o,
    output logic [7:0]       mem_be_o,
    output logic [1:0]       mem_size_o,
    output logic             mem_tag_valid_o,
    output logic             mem_kill_o,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        TAG  = 2'd2,
        WAIT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               drop_q, drop_d;
    logic [IDX_W-1:0]   index_q;
    logic [TAG_W-1:0]   tag_q;
    logic [63:0]        wdata_q;
    logic [7:0]         be_q;
    logic [1:0]         size_q;
    logic               we_q;

    logic ld_elig, st_elig, st_win, ld_win, owner_kill, cap_ld, cap_st;

    assign ld_elig    = ld_valid_i & ~ld_kill_i;
    assign st_elig    = st_valid_i & ~st_kill_i;
    assign st_win     = st_elig & (~ld_elig | (starve_q == CNT_W'(STARVE_MAX)));
    assign ld_win     = ld_elig & ~st_win;
    // The holding register's we bit doubles as the owner flag.
    assign owner_kill = we_q ? st_kill_i : ld_kill_i;

    always_comb begin
        state_d         = state_q;
        starve_d        = starve_q;
        drop_d          = drop_q;
        cap_ld          = 1'b0;
        cap_st          = 1'b0;
        ld_ack_o        = 1'b0;
        st_ack_o        = 1'b0;
        mem_valid_o     = 1'b0;
        mem_tag_valid_o = 1'b0;
        mem_kill_o      = 1'b0;
        st_done_o       = 1'b0;
        ld_resp_valid_o = 1'b0;
        ld_resp_data_o  = 64'd0;
        case (state_q)
            IDLE: begin
                cap_ld   = ld_win & rstn_i;
                cap_st   = st_win & rstn_i;
                ld_ack_o = cap_ld;
                st_ack_o = cap_st;
                if (cap_st) begin
                    starve_d = '0;
                    state_d  = REQ;
                end else if (cap_ld) begin
                    if (st_valid_i && (starve_q != CNT_W'(STARVE_MAX)))
                        starve_d = starve_q + 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_valid_o = ~owner_kill;
                if (owner_kill)
                    state_d = IDLE;
                else if (mem_gnt_i)
                    state_d = TAG;
            end
            TAG: begin
                mem_tag_valid_o = 1'b1;
                mem_kill_o      = owner_kill;
                drop_d          = 1'b0;
                if (we_q) begin
                    st_done_o = ~owner_kill;
                    state_d   = IDLE;
                end else if (owner_kill) begin
                    state_d = IDLE;
                end else if (mem_rvalid_i) begin
                    ld_resp_valid_o = 1'b1;
                    ld_resp_data_o  = mem_rdata_i;
                    state_d         = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    ld_resp_valid_o = ~(drop_q | ld_kill_i);
                    ld_resp_data_o  = mem_rdata_i;
                    drop_d          = 1'b0;
                    state_d         = IDLE;
                end else begin
                    drop_d = drop_q | ld_kill_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            starve_q <= '0;
            drop_q   <= 1'b0;
            index_q  <= '0;
            tag_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
            if (cap_st) begin
                index_q <= st_index_i;
                tag_q   <= st_tag_i;
                wdata_q <= st_wdata_i;
                be_q    <= st_be_i;
                size_q  <= st_size_i;
                we_q    <= 1'b1;
            end else if (cap_ld) begin
                index_q <= ld_index_i;
                tag_q   <= ld_tag_i;
                wdata_q <= ld_wdata_i;
                be_q    <= ld_be_i;
                size_q  <= ld_size_i;
                we_q    <= 1'b0;
            end
        end
    end

    assign mem_index_o = index_q;
    assign mem_tag_o   = tag_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign mem_size_o  = size_q;
    assign mem_we_o    = we_q;

endmodule

`default_nettype wire

// File: doc/lagarto_dcache_port_arbiter.md
# lagarto_dcache_port_arbiter

Shares the single L1 D-cache request port between the Lagarto load path and store path. It arbitrates with load priority and a store starvation guard, and captures the winning request into a holding register. It sequences the two-phase index/tag protocol and tracks the outstanding load until its response returns. It sits between the load/store adapter and the D-cache subsystem.

## Interface
Parameters:
- IDX_W, 12: D-cache index width.
- TAG_W, 44: D-cache tag width.
- STARVE_MAX, 4: consecutive lost arbitrations after which a pending store wins.

Ports (`x` is `ld` or `st`; each requester has the same request bundle):
- clk_i  in  1  clock; all logic rising-edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- x_valid_i  in  1  request pending.
- x_ack_o  out  1  request captured this cycle.
- x_index_i  in  IDX_W  cache index.
- x_tag_i  in  TAG_W  cache tag.
- x_wdata_i  in  64  store data (ignored for ld).
- x_be_i  in  8  byte enables.
- x_size_i  in  2  transfer size.
- x_kill_i  in  1  kill owner's in-flight request.
- ld_resp_valid_o  out  1  load data valid.
- ld_resp_data_o  out  64  load data.
- st_done_o  out  1  store accepted by cache.
- mem_valid_o  out  1  index-phase request.
- mem_gnt_i  in  1  cache accepted index phase.
- mem_index_o  out  IDX_W  held index.
- mem_tag_o  out  TAG_W  held tag.
- mem_wdata_o  out  64  held data.
- mem_we_o  out  1  1 = store.
- mem_be_o  out  8  held byte enables.
- mem_size_o  out  2  held size.
- mem_tag_valid_o  out  1  tag phase.
- mem_kill_o  out  1  kill tag-phase request.
- mem_rvalid_i  in  1  load response.
- mem_rdata_i  in  64  response data.

## Operation
- States: IDLE, REQ, TAG, WAIT.
- IDLE:
  - Winner selection: ld wins if ld_valid_i, unless st_valid_i and starve_cnt == STARVE_MAX, in which case st wins.
  - Winner's x_ack_o is asserted combinationally.
  - Capture: bundle and owner (ld/st) are registered; next state is REQ.
  - Killed requester: a requester whose x_kill_i is high is not eligible.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments, saturating at STARVE_MAX, on each capture where ld wins while st_valid_i = 1.
  - Clears when st is captured.
  - Otherwise holds.
- REQ:
  - mem_valid_o = ~owner_kill.
  - mem_gnt_i while mem_valid_o: next state is TAG.
  - owner_kill: next state is IDLE; no cache side effect.
  - mem_gnt_i is ignored while mem_valid_o = 0.
- TAG (exactly one cycle):
  - Outputs: mem_tag_valid_o = 1, mem_kill_o = owner_kill.
  - Store: st_done_o = ~owner_kill; next state is IDLE.
  - Load, not killed: if mem_rvalid_i arrives in this cycle, respond now and go to IDLE; otherwise go to WAIT.
  - Load, killed: next state is IDLE; the cache returns no rvalid.
- WAIT:
  - Kill: ld_kill_i sets the drop flag.
  - On mem_rvalid_i:
    - ld_resp_valid_o = ~(drop | ld_kill_i).
    - ld_resp_data_o = mem_rdata_i.
    - Next state is IDLE; drop clears.
  - mem_rvalid_i outside TAG/WAIT(load) is ignored.
- mem_index/tag/wdata/be/size/we_o are driven from the holding register in every state. They change only on capture.
- Kill from a non-owner requester while the port is busy has no effect on the in-flight request.

## Timing
- Reset: all outputs and the holding register are 0, state is IDLE, starve_cnt = 0, drop = 0.
- Reset mid-operation: returns to IDLE immediately and asynchronously; the outstanding response is forgotten.
- Capture at cycle T (ack at T); mem_valid_o from T+1.
- Gnt at T+1: TAG at T+2; st_done_o at T+2; the next capture can occur in IDLE at T+3.
- Load, earliest response is at T+2 (in TAG); ld_resp_valid_o is combinational from mem_rvalid_i.
- Back-to-back minimum: one capture per 3 cycles for stores and for zero-wait loads.
- No requester is acked while state ≠ IDLE.
- A requester's valid must hold until ack; fields may change only after ack.

## Test plan
- Single load: ld_valid_i at T, gnt at T+1, rvalid with 0xDEADBEEF at T+5 -> ld_ack_o@T, mem_tag_valid_o@T+2, ld_resp_valid_o=1 with 0xDEADBEEF@T+5, state IDLE@T+6.
- Store: st_valid_i with be=0x0F, wdata=0x1234, gnt delayed 3 cycles -> mem_valid_o held 3 cycles with mem_we_o=1, be=0x0F; st_done_o one cycle in TAG.
- Starvation: ld_valid_i and st_valid_i both held continuously, STARVE_MAX=4 -> four ld captures, then st captured on the fifth arbitration, starve_cnt=0 after.
- Kill in REQ: ld_kill_i asserted the cycle after ack, with gnt high -> mem_valid_o=0, no TAG phase, IDLE next cycle, no response.
- Kill in WAIT: ld_kill_i pulse during WAIT, rvalid 4 cycles later -> ld_resp_valid_o stays 0, port busy until rvalid, then IDLE.
- Reset mid-WAIT: rstn_i low in WAIT -> all outputs 0 immediately; a later stray rvalid produces no ld_resp_valid_o.
